// File: rtl/data_mem_lsu.sv
// data_mem_lsu
// -------------
// Byte-addressable data memory for the MEM stage. Handles byte, halfword and
// word loads and stores selected by funct3, with sign or zero extension of
// loads and byte-lane writes for stores. Misaligned, illegal-size and
// out-of-range accesses are detected and suppressed.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset (outputs only)
//   Address_i      byte address of the access
//   WriteData_i    store data, low-aligned for SB/SH
//   ReadEn_i       load request
//   WriteEn_i      store request
//   Funct3_i       access size: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   Data_o         registered, extended load result (held between loads)
//   DataValid_o    pulse: load result available
//   Misaligned_o   pulse: access faulted on alignment or illegal size
//   OutOfRange_o   pulse: access fell outside the mapped range
//
// Handshake: there is no ready. Any cycle with rst=0 and ReadEn_i|WriteEn_i
// accepts one access. Stores land at the accepting edge. The word for a load
// is captured at the accepting edge, and the result is presented together
// with DataValid_o and any fault flag after the following edge.
module data_mem_lsu #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Address_i,
    input  logic [31:0] WriteData_i,
    input  logic        ReadEn_i,
    input  logic        WriteEn_i,
    input  logic [2:0]  Funct3_i,
    output logic [31:0] Data_o,
    output logic        DataValid_o,
    output logic        Misaligned_o,
    output logic        OutOfRange_o
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Request decode
    logic [31:0]   offset;
    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic          accept;
    logic          oor_fault;
    logic          mis_fault;
    logic          wr_en;
    logic [3:0]    byte_en;
    logic [31:0]   wdata_rep;

    always_comb begin
        offset    = Address_i - BASE_ADDR;
        word_idx  = offset[AW+1:2];
        lane      = offset[1:0];
        accept    = !rst && (ReadEn_i || WriteEn_i);
        // Any set bit above the mapped window faults; an address below
        // BASE_ADDR wraps to a large offset and lands here as well.
        oor_fault = (offset[31:AW+2] != '0);
        mis_fault = 1'b0;
        byte_en   = 4'b0000;
        wdata_rep = WriteData_i;
        case (Funct3_i)
            3'b000: begin
                byte_en   = 4'b0001 << lane;
                wdata_rep = {4{WriteData_i[7:0]}};
            end
            3'b001: begin
                mis_fault = lane[0];
                byte_en   = 4'b0011 << lane;
                wdata_rep = {2{WriteData_i[15:0]}};
            end
            3'b010: begin
                mis_fault = (lane != 2'b00);
                byte_en   = 4'b1111;
            end
            3'b100:  mis_fault = WriteEn_i;
            3'b101:  mis_fault = WriteEn_i || lane[0];
            default: mis_fault = 1'b1;
        endcase
        wr_en = accept && WriteEn_i && !oor_fault && !mis_fault;
    end

    // Memory write port; contents are intentionally untouched by rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem_q[word_idx][b*8 +: 8] <= wdata_rep[b*8 +: 8];
                end
            end
        end
    end

    // Stage 1: capture the pre-store word and the access attributes.
    logic        ld_pend_q, ld_pend_d;
    logic [31:0] ld_word_q, ld_word_d;
    logic [1:0]  ld_lane_q, ld_lane_d;
    logic [2:0]  ld_f3_q,   ld_f3_d;
    logic        pmis_q,    pmis_d;
    logic        poor_q,    poor_d;

    // Stage 2: architectural outputs.
    logic [31:0] data_q,  data_d;
    logic        valid_q, valid_d;
    logic        mis_q,   mis_d;
    logic        oor_q,   oor_d;

    logic [31:0] shifted;
    logic [31:0] ext;

    always_comb begin
        ld_pend_d = accept && ReadEn_i;
        ld_word_d = mem_q[word_idx];
        ld_lane_d = lane;
        ld_f3_d   = Funct3_i;
        // Range fault outranks the alignment/size fault.
        poor_d    = accept && oor_fault;
        pmis_d    = accept && !oor_fault && mis_fault;
        if (rst) begin
            ld_pend_d = 1'b0;
            pmis_d    = 1'b0;
            poor_d    = 1'b0;
        end
    end

    always_comb begin
        shifted = ld_word_q >> {ld_lane_q, 3'b000};
        case (ld_f3_q)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ext = {24'h0, shifted[7:0]};
            3'b101:  ext = {16'h0, shifted[15:0]};
            default: ext = shifted;
        endcase

        valid_d = ld_pend_q;
        mis_d   = pmis_q;
        oor_d   = poor_q;
        data_d  = data_q;
        if (ld_pend_q) begin
            data_d = (pmis_q || poor_q) ? 32'h0 : ext;
        end
        if (rst) begin
            valid_d = 1'b0;
            mis_d   = 1'b0;
            oor_d   = 1'b0;
            data_d  = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        ld_pend_q <= ld_pend_d;
        ld_word_q <= ld_word_d;
        ld_lane_q <= ld_lane_d;
        ld_f3_q   <= ld_f3_d;
        pmis_q    <= pmis_d;
        poor_q    <= poor_d;
        data_q    <= data_d;
        valid_q   <= valid_d;
        mis_q     <= mis_d;
        oor_q     <= oor_d;
    end

    assign Data_o       = data_q;
    assign DataValid_o  = valid_q;
    assign Misaligned_o = mis_q;
    assign OutOfRange_o = oor_q;
endmodule

// File: tb/tb_data_mem_lsu.sv
module tb_data_mem_lsu;
  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clk;
  logic        rst;
  logic [31:0] address_i;
  logic [31:0] write_data_i;
  logic        read_en_i;
  logic        write_en_i;
  logic [2:0]  funct3_i;
  logic [31:0] data_o;
  logic        data_valid_o;
  logic        misaligned_o;
  logic        out_of_range_o;

  int n_checks = 0;
  int n_passed = 0;

  data_mem_lsu #(
    .DEPTH_WORDS(16),
    .BASE_ADDR  (32'h0000_0000),
    .INIT_FILE  ("")
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Address_i   (address_i),
    .WriteData_i (write_data_i),
    .ReadEn_i    (read_en_i),
    .WriteEn_i   (write_en_i),
    .Funct3_i    (funct3_i),
    .Data_o      (data_o),
    .DataValid_o (data_valid_o),
    .Misaligned_o(misaligned_o),
    .OutOfRange_o(out_of_range_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // drivers
  task automatic drive(input logic re, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    read_en_i    = re;
    write_en_i   = we;
    funct3_i     = f3;
    address_i    = a;
    write_data_i = wd;
  endtask

  task automatic idle();
    @(negedge clk);
    read_en_i  = 1'b0;
    write_en_i = 1'b0;
  endtask

  // Checks all outputs one edge after the accepting edge of the last request.
  task automatic check_out(input string tag, input logic [31:0] exp_d, input logic exp_v,
                           input logic exp_m, input logic exp_o);
    idle();
    @(negedge clk);
    check({tag, ".data"}, data_o, exp_d);
    check({tag, ".valid"}, {31'h0, data_valid_o}, {31'h0, exp_v});
    check({tag, ".mis"}, {31'h0, misaligned_o}, {31'h0, exp_m});
    check({tag, ".oor"}, {31'h0, out_of_range_o}, {31'h0, exp_o});
  endtask

  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] exp_d, input logic exp_m, input logic exp_o);
    drive(1'b1, 1'b0, f3, a, 32'h0);
    check_out(tag, exp_d, 1'b1, exp_m, exp_o);
  endtask

  // Stores never touch Data_o, so the held value is passed in as expectation.
  task automatic store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] held,
                       input logic exp_m, input logic exp_o);
    drive(1'b0, 1'b1, f3, a, wd);
    check_out(tag, held, 1'b0, exp_m, exp_o);
  endtask

  initial begin
    rst = 1'b1;
    read_en_i = 1'b0;
    write_en_i = 1'b0;
    funct3_i = F_W;
    address_i = 32'h0;
    write_data_i = 32'h0;
    // Requests during reset are discarded.
    drive(1'b1, 1'b1, F_W, 32'h0, 32'h1234_5678);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst.data", data_o, 32'h0);
    check("rst.valid", {31'h0, data_valid_o}, 32'h0);
    check("rst.mis", {31'h0, misaligned_o}, 32'h0);
    check("rst.oor", {31'h0, out_of_range_o}, 32'h0);
    rst = 1'b0;

    // Word store and load
    store("sw0", F_W, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    load("lw0", F_W, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    @(negedge clk);
    check("valid_pulse", {31'h0, data_valid_o}, 32'h0);

    // Byte store only touches lane 1
    store("sb1", F_B, 32'h1, 32'h1234_5680, 32'hDEAD_BEEF, 1'b0, 1'b0);
    load("lb1", F_B, 32'h1, 32'hFFFF_FF80, 1'b0, 1'b0);
    load("lbu1", F_BU, 32'h1, 32'h0000_0080, 1'b0, 1'b0);
    load("lw0b", F_W, 32'h0, 32'hDEAD_80EF, 1'b0, 1'b0);
    load("lb3", F_B, 32'h3, 32'hFFFF_FFDE, 1'b0, 1'b0);
    load("lbu2", F_BU, 32'h2, 32'h0000_00AD, 1'b0, 1'b0);
    load("lh2", F_H, 32'h2, 32'hFFFF_DEAD, 1'b0, 1'b0);

    // Halfwords
    store("sh6", F_H, 32'h6, 32'hABCD_1234, 32'hFFFF_DEAD, 1'b0, 1'b0);
    store("sh4", F_H, 32'h4, 32'h5555_8001, 32'hFFFF_DEAD, 1'b0, 1'b0);
    load("lh6", F_H, 32'h6, 32'h0000_1234, 1'b0, 1'b0);
    load("lh4", F_H, 32'h4, 32'hFFFF_8001, 1'b0, 1'b0);
    load("lhu4", F_HU, 32'h4, 32'h0000_8001, 1'b0, 1'b0);
    load("lw4", F_W, 32'h4, 32'h1234_8001, 1'b0, 1'b0);

    // Alignment and illegal-size faults
    load("lh5", F_H, 32'h5, 32'h0, 1'b1, 1'b0);
    load("lw4_after_lh5", F_W, 32'h4, 32'h1234_8001, 1'b0, 1'b0);
    store("sw2", F_W, 32'h2, 32'h1111_1111, 32'h1234_8001, 1'b1, 1'b0);
    load("lw0_after_sw2", F_W, 32'h0, 32'hDEAD_80EF, 1'b0, 1'b0);
    load("ld_f3_011", 3'b011, 32'h0, 32'h0, 1'b1, 1'b0);
    store("sbu", F_BU, 32'h0, 32'h0000_0055, 32'h0, 1'b1, 1'b0);
    store("shu", F_HU, 32'h0, 32'h0000_5555, 32'h0, 1'b1, 1'b0);
    load("lw0_after_sbu", F_W, 32'h0, 32'hDEAD_80EF, 1'b0, 1'b0);

    // Read-before-write on the same address
    store("sw_ae", F_W, 32'h0, 32'h0000_00AE, 32'hDEAD_80EF, 1'b0, 1'b0);
    drive(1'b1, 1'b1, F_W, 32'h0, 32'h0000_00DA);
    check_out("rbw", 32'h0000_00AE, 1'b1, 1'b0, 1'b0);
    load("lw_da", F_W, 32'h0, 32'h0000_00DA, 1'b0, 1'b0);

    // Range faults (16-word window = 0x00..0x3F)
    load("lw40", F_W, 32'h40, 32'h0, 1'b0, 1'b1);
    store("sw40", F_W, 32'h40, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
    load("lw0_after_sw40", F_W, 32'h0, 32'h0000_00DA, 1'b0, 1'b0);
    load("lh41_both", F_H, 32'h41, 32'h0, 1'b0, 1'b1);
    load("lw_top", F_W, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1);

    // Back-to-back store then load of the last word
    drive(1'b0, 1'b1, F_W, 32'h3C, 32'hCAFE_F00D);
    drive(1'b1, 1'b0, F_W, 32'h3C, 32'h0);
    check_out("b2b", 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0);

    // Stores leave Data_o held
    store("hold", F_W, 32'h8, 32'h0BAD_0BAD, 32'hCAFE_F00D, 1'b0, 1'b0);

    // Reset on the result edge loses the pending load
    drive(1'b1, 1'b0, F_W, 32'h3C, 32'h0);
    idle();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid.data", data_o, 32'h0);
    check("rst_mid.valid", {31'h0, data_valid_o}, 32'h0);
    rst = 1'b0;
    load("lw3c_after_rst", F_W, 32'h3C, 32'hCAFE_F00D, 1'b0, 1'b0);
    load("lw8_after_rst", F_W, 32'h8, 32'h0BAD_0BAD, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
